// File: rtl/bam_pkg.sv
// bam_pkg: shared types and helpers for the broken-array multiplier family.
//   bam_state_e  : control state of the sequential multiplier
//   hw_width(n)  : width of a horizontal cut able to express 0..n
//   vw_width(n)  : width of a vertical cut able to express 0..2n-1
//   row_width(n) : width of a row index 0..n-1
//   bam_ref(...) : untimed golden model of the approximate product
package bam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bam_state_e;

  function automatic int hw_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int vw_width(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic int row_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Sum of every partial-product bit a[j]&b[i] that survives both cuts.
  function automatic logic [63:0] bam_ref(input int n, input logic [31:0] a,
                                          input logic [31:0] b, input int h,
                                          input int v);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (i >= h && (i + j) >= v && a[j] && b[i])
          s = s + (64'd1 << (i + j));
    return s;
  endfunction

endpackage

// File: rtl/bam_row_mask.sv
// bam_row_mask: one partial-product row with the vertical cut applied.
//   a      [N]  multiplicand
//   b_bit  [1]  multiplier bit selecting this row
//   row    [RW] row index (weight of b_bit)
//   v_cut  [VW] columns below this weight are dropped
//   m      [N]  masked row, bit j has weight row+j
module bam_row_mask #(
  parameter int N  = 8,
  parameter int RW = 3,
  parameter int VW = 4
) (
  input  logic [N-1:0]  a,
  input  logic          b_bit,
  input  logic [RW-1:0] row,
  input  logic [VW-1:0] v_cut,
  output logic [N-1:0]  m
);

  // One extra bit so row+j never wraps before the compare.
  localparam int CW = VW + 1;

  for (genvar j = 0; j < N; j++) begin : g_bit
    logic [CW-1:0] col;
    assign col  = CW'(row) + CW'(j);
    assign m[j] = a[j] & b_bit & (col >= CW'(v_cut));
  end

endmodule

// File: rtl/seq_bam_mul.sv
// seq_bam_mul: sequential broken-array unsigned multiplier, one row per cycle.
//   clk, rst_n           clock / async active-low reset
//   in_valid, in_ready   operand bundle handshake (a, b, h_cut, v_cut)
//   a, b      [N]        unsigned operands
//   h_cut     [HW]       rows b[i] with i < h_cut are skipped
//   v_cut     [VW]       bits with weight i+j < v_cut are dropped
//   out_valid, out_ready result handshake
//   p         [2N]       approximate product
module seq_bam_mul
  import bam_pkg::*;
#(
  parameter int N  = 8,
  parameter int HW = hw_width(N),
  parameter int VW = vw_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [HW-1:0] h_cut,
  input  logic [VW-1:0] v_cut,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*N-1:0] p
);

  localparam int RW = row_width(N);

  bam_state_e     state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [VW-1:0]  v_q;
  logic [RW-1:0]  row_q;
  logic [2*N-1:0] acc_q;
  logic [N-1:0]   row_bits;
  logic           accept, last_row, full_cut;

  assign accept   = in_valid && in_ready;
  assign last_row = (row_q == RW'(N - 1));
  assign full_cut = (h_cut >= HW'(N));

  bam_row_mask #(.N(N), .RW(RW), .VW(VW)) u_mask (
    .a     (a_q),
    .b_bit (b_q[row_q]),
    .row   (row_q),
    .v_cut (v_q),
    .m     (row_bits)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = full_cut ? DONE : CALC;
      CALC: if (last_row) state_d = DONE;
      DONE: begin
        // A bundle arriving with the drain is taken in the same edge.
        if (accept)         state_d = full_cut ? DONE : CALC;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = rst_n && ((state_q == IDLE) || (state_q == DONE && out_ready));
    out_valid = (state_q == DONE);
    p         = acc_q;
  end

  // Datapath: operands captured at accept, one row accumulated per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      v_q   <= '0;
      row_q <= '0;
      acc_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      v_q   <= v_cut;
      // Truncation is harmless: a full cut never visits CALC.
      row_q <= h_cut[RW-1:0];
      acc_q <= '0;
    end else if (state_q == CALC) begin
      acc_q <= acc_q + ({{N{1'b0}}, row_bits} << row_q);
      if (!last_row) row_q <= row_q + RW'(1);
    end
  end

endmodule

// File: tb/tb_seq_bam_mul.sv
module tb_seq_bam_mul;
  import bam_pkg::*;

  localparam int N = 8;
  localparam int K = 3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [3:0]  h_cut, v_cut;
  logic [15:0] p;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_bam_mul #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .h_cut(h_cut), .v_cut(v_cut),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Each surviving row is a<<i with everything below weight v cleared.
  function automatic logic [15:0] model(input int ma, input int mb, input int mh, input int mv);
    longint s, keep;
    s = 0;
    keep = ~((longint'(1) << mv) - 1);
    for (int i = mh; i < N; i++)
      if (((mb >> i) & 1) != 0) s += (longint'(ma) << i) & keep;
    return s[15:0];
  endfunction

  // Present a bundle, wait for it to be accepted, then count edges to out_valid.
  // A full cut lands in DONE on the accept edge itself (0 further edges).
  task automatic run_op(input string tag, input int ta, input int tb_, input int th,
                        input int tv, input int exp_p, input int exp_lat, input bit drain);
    int w, lat;
    @(negedge clk);
    a = 8'(ta); b = 8'(tb_); h_cut = 4'(th); v_cut = 4'(tv);
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); #1; w++; end
    chk({tag, "_accept_to"}, (w < 50), 1);
    @(posedge clk); #1;
    // Scramble inputs after accept; they must not matter.
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); h_cut = 4'($urandom); v_cut = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_p"}, p, exp_p);
    if (drain) begin
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] held_p, exp_v, prev_p;
    logic [15:0] exp_q[$];
    int got, sent, cyc, lat;
    bit seen, prev_stall, acc_pending;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; h_cut = '0; v_cut = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_in_ready", in_ready, 1);

    chk("pkg_ref", bam_ref(8, 255, 255, 3, 10), 58368);

    run_op("exact_ff",  255, 255, 0, 0,  65025, 8, 1);
    run_op("exact_13",  13,  11,  0, 0,  143,   8, 1);
    run_op("approx",    255, 255, 3, 10, 58368, 5, 1);
    run_op("full_h",    201, 177, 8, 0,  0,     0, 1);
    run_op("full_v",    255, 255, 0, 15, 0,     8, 1);

    // Backpressure then back-to-back accept from DONE.
    run_op("bp", 200, 100, 0, 0, 20000, 8, 0);
    held_p = p;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_p", p, held_p);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 8'd3; b = 8'd5; h_cut = 4'd0; v_cut = 4'd0;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_out_valid", out_valid, 0);
    chk("b2b_calc_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_lat", lat, 8);
    chk("b2b_p", p, 15);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset while row 4 is next to be processed.
    @(negedge clk);
    a = 8'd255; b = 8'd255; h_cut = 4'd0; v_cut = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_p", p, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("post_rst_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    chk("no_stale_result", seen, 0);

    // Randomised traffic against the queue-based reference.
    got = 0; sent = 0; cyc = 0; prev_stall = 1'b0; prev_p = '0; acc_pending = 1'b0;
    while (got < K && cyc < 60000) begin
      @(negedge clk); cyc++;
      if (acc_pending) begin in_valid = 1'b0; acc_pending = 1'b0; end
      if (!in_valid && sent < K && ($urandom_range(3) != 0)) begin
        a = 8'($urandom); b = 8'($urandom);
        h_cut = 4'($urandom_range(8)); v_cut = 4'($urandom_range(15));
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom);
      #1;
      if (prev_stall) begin
        chk("rand_hold_valid", out_valid, 1);
        chk("rand_hold_p", p, prev_p);
      end
      if (out_valid && out_ready) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk("rand_p", p, exp_v);
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(a), int'(b), int'(h_cut), int'(v_cut)));
        sent++;
        acc_pending = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      prev_p = p;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_count", got, K);
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
